// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned IMEM_LAT_DEF = 1;
    localparam int unsigned WAIT_MAX_DEF = 255;
    localparam int unsigned CNT_W_DEF    = 32;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter: async reset, synchronous clear, sticks at all-ones.
module hazard_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count enabled cycles; clear wins over enable; never wrap past all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the 5-stage core: load-use bubbles, taken-branch
// redirects with wrong-path squash, data-memory wait stalls with timeout, and
// saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned IMEM_LAT = IMEM_LAT_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic              br_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              stall_m_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              pc_sel_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned RCNT_W = cnt_width(IMEM_LAT - 1);
    localparam int unsigned WAIT_W = cnt_width(WAIT_MAX);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(IMEM_LAT - 1);

    hz_state_e         state_q, state_d;
    logic              ret_redir_q, ret_redir_d;   // MEM_WAIT resumes into REDIRECT
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall, load_use, redir_ctx;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_sel;

    assign mem_stall = dmem_req_i & ~dmem_ack_i;
    assign load_use  = ex_mem_read_i && (ex_rd_i != '0) &&
                       ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    // Once the wait ends, rules of the state we stalled out of apply that same cycle.
    assign redir_ctx = (state_q == REDIRECT) || ((state_q == MEM_WAIT) && ret_redir_q);

    // Next state and control outputs; priority mem_stall > redirect > load_use.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        pc_sel      = 1'b0;
        state_d     = state_q;
        ret_redir_d = ret_redir_q;
        rcnt_d      = rcnt_q;
        if (mem_stall) begin
            stall_f     = 1'b1;
            stall_d     = 1'b1;
            stall_e     = 1'b1;
            stall_m     = 1'b1;
            state_d     = MEM_WAIT;
            ret_redir_d = redir_ctx;
        end else if (br_taken_i) begin
            pc_sel      = 1'b1;
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            ret_redir_d = 1'b0;
            if (IMEM_LAT > 1) begin
                state_d = REDIRECT;
                rcnt_d  = RCNT_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else if (redir_ctx) begin
            flush_d     = 1'b1;
            ret_redir_d = 1'b0;
            if (rcnt_q <= RCNT_W'(1)) begin
                state_d = RUN;
            end else begin
                state_d = REDIRECT;
                rcnt_d  = rcnt_q - RCNT_W'(1);
            end
        end else begin
            state_d     = RUN;
            ret_redir_d = 1'b0;
            if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Timeout latches on the stall cycle that brings the wait count to WAIT_MAX.
    always_comb begin
        timeout_d = timeout_q;
        if (mem_stall && ((32'(wait_cnt) + 32'd1) >= WAIT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    // State, redirect counter and sticky timeout registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            ret_redir_q <= 1'b0;
            rcnt_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_redir_q <= ret_redir_d;
            rcnt_q      <= rcnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Reset forces every control output low even while stall inputs are active.
    assign stall_f_o = rst_ni & stall_f;
    assign stall_d_o = rst_ni & stall_d;
    assign stall_e_o = rst_ni & stall_e;
    assign stall_m_o = rst_ni & stall_m;
    assign flush_d_o = rst_ni & flush_d;
    assign flush_e_o = rst_ni & flush_e;
    assign pc_sel_o  = rst_ni & pc_sel;
    assign timeout_o = timeout_q;

    hazard_sat_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (mem_stall),
        .clr_i  (~mem_stall),
        .cnt_o  (wait_cnt)
    );

    hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (stall_f_o),
        .clr_i  (1'b0),
        .cnt_o  (stall_cnt_o)
    );

    hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (pc_sel_o),
        .clr_i  (1'b0),
        .cnt_o  (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal scenarios followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned IMEM_LAT = 3;
    localparam int unsigned WAIT_MAX = 8;
    localparam int unsigned CNT_W    = 5;
    localparam int          CMAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              use1, use2, ex_mem_read, br, req, ack;
    logic              stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_sel, timeout;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    wire [6:0] ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_sel};

    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_MEM   = 7'b1111000;
    localparam logic [6:0] C_BR    = 7'b0000111;
    localparam logic [6:0] C_SQUASH= 7'b0000100;
    localparam logic [6:0] C_LU    = 7'b1100010;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(
        .REG_AW(REG_AW), .IMEM_LAT(IMEM_LAT), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .br_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
        .flush_d_o(flush_d), .flush_e_o(flush_e), .pc_sel_o(pc_sel),
        .timeout_o(timeout), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        use1 = 1'b0; use2 = 1'b0; ex_mem_read = 1'b0;
        br = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        next();
        set_idle();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
    endtask

    // Behavioural model: pending wrong-path squash cycles, consecutive wait
    // length, sticky timeout and saturating event counts.
    int pend = 0;
    int stall_run = 0;
    bit to_m = 1'b0;
    int scnt_m = 0;
    int fcnt_m = 0;

    always @(negedge clk) begin
        logic       ms, lu;
        logic [6:0] e;
        if (!rst_n) begin
            check("rst_ctrl", ctrl, C_IDLE);
            check("rst_timeout", timeout, 0);
            check("rst_stall_cnt", stall_cnt, 0);
            check("rst_flush_cnt", flush_cnt, 0);
            pend = 0; stall_run = 0; to_m = 1'b0; scnt_m = 0; fcnt_m = 0;
        end else begin
            ms = req && !ack;
            lu = ex_mem_read && (ex_rd != 0) &&
                 ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
            if (ms)            e = C_MEM;
            else if (br)       e = C_BR;
            else if (pend > 0) e = C_SQUASH;
            else if (lu)       e = C_LU;
            else               e = C_IDLE;
            check("ctrl", ctrl, e);
            check("timeout", timeout, to_m);
            check("stall_cnt", stall_cnt, scnt_m);
            check("flush_cnt", flush_cnt, fcnt_m);
            if (ms) begin
                stall_run++;
                if (stall_run >= WAIT_MAX) to_m = 1'b1;
            end else begin
                stall_run = 0;
                if (br) pend = IMEM_LAT - 1;
                else if (pend > 0) pend--;
            end
            if (e[6] && scnt_m < CMAX) scnt_m++;
            if (e[0] && fcnt_m < CMAX) fcnt_m++;
        end
    end

    initial begin
        int ack_pct;
        set_idle();
        rst_n = 1'b0;
        next(); next();
        check("lit_rst_ctrl", ctrl, C_IDLE);
        check("lit_rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // Load-use bubble, then self-clearing, and rd=0 never stalls
        next(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; use1 = 1; #1;
        check("lit_lu_stall", ctrl, C_LU);
        next(); set_idle(); #1;
        check("lit_lu_clear", ctrl, C_IDLE);
        next(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; use1 = 1; #1;
        check("lit_lu_rd0", ctrl, C_IDLE);

        // Taken branch with three wrong-path fetch cycles
        apply_reset();
        next(); br = 1; #1;
        check("lit_br_c0", ctrl, C_BR);
        next(); br = 0; #1;
        check("lit_br_c1", ctrl, C_SQUASH);
        next(); #1;
        check("lit_br_c2", ctrl, C_SQUASH);
        next(); #1;
        check("lit_br_c3", ctrl, C_IDLE);
        check("lit_br_flush_cnt", flush_cnt, 1);

        // Memory wait of four cycles, released on ack
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            next(); req = 1; ack = 0; #1;
            check("lit_mem_stall", ctrl, C_MEM);
        end
        next(); ack = 1; #1;
        check("lit_mem_ack", ctrl, C_IDLE);
        next(); set_idle(); #1;
        check("lit_mem_stall_cnt", stall_cnt, 4);

        // Timeout after WAIT_MAX wait cycles, sticky past ack, cleared by reset
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            next(); req = 1; ack = 0; #1;
            check("lit_timeout_rise", timeout, (k >= 9) ? 1 : 0);
        end
        next(); ack = 1;
        next(); set_idle(); #1;
        check("lit_timeout_sticky", timeout, 1);
        apply_reset(); #1;
        check("lit_timeout_cleared", timeout, 0);

        // Memory stall in the middle of a redirect squash
        next(); br = 1; #1;
        check("lit_rs_br", ctrl, C_BR);
        next(); br = 0; req = 1; ack = 0; #1;
        check("lit_rs_stall0", ctrl, C_MEM);
        next(); #1;
        check("lit_rs_stall1", ctrl, C_MEM);
        next(); ack = 1; #1;
        check("lit_rs_ack", ctrl, C_SQUASH);
        next(); set_idle(); #1;
        check("lit_rs_last", ctrl, C_SQUASH);
        next(); #1;
        check("lit_rs_done", ctrl, C_IDLE);

        // Branch beats load-use; reset in the middle of a memory wait
        apply_reset();
        next(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; use2 = 1; br = 1; #1;
        check("lit_br_vs_lu", ctrl, C_BR);
        apply_reset();
        next(); req = 1; ack = 0;
        next(); #1;
        check("lit_wait_stall", ctrl, C_MEM);
        #1 rst_n = 1'b0;
        #1;
        check("lit_async_rst_ctrl", ctrl, C_IDLE);
        check("lit_async_rst_cnt", stall_cnt, 0);
        next(); set_idle();
        next(); rst_n = 1'b1;
        next(); #1;
        check("lit_after_rst", ctrl, C_IDLE);

        // Randomized traffic, checked by the model every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) begin
                apply_reset();
            end else begin
                next();
                ack_pct = ((cyc % 200) < 100) ? 50 : 8;
                if (!(req && !ack)) req = ($urandom_range(0, 99) < 35);
                ack = req ? ($urandom_range(0, 99) < ack_pct) : 1'($urandom_range(0, 1));
                br = ($urandom_range(0, 99) < 15);
                ex_mem_read = ($urandom_range(0, 99) < 40);
                ex_rd  = REG_AW'($urandom_range(0, 3));
                id_rs1 = REG_AW'($urandom_range(0, 3));
                id_rs2 = REG_AW'($urandom_range(0, 3));
                use1 = 1'($urandom_range(0, 1));
                use2 = 1'($urandom_range(0, 1));
            end
        end
        next(); set_idle();
        next(); next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
